// File: rtl/wb_arbiter_2m1s.sv
// Two-master / one-slave Wishbone pipelined arbiter with round-robin grant on
// contention, outstanding-request tracking and a slave-response timeout.
module wb_arbiter_2m1s #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,

  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_stall_o,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_stall_o,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_stall_i,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_err_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT     = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [7:0]           TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic                   last_grant_r, last_grant_nxt_s;
  logic [CNT_WIDTH-1:0]   outstanding_r, outstanding_nxt_s;
  logic [7:0]             timer_r, timer_nxt_s;

  logic owner_cyc_s, owner_stb_s, other_cyc_s;
  logic full_s, pending_s, req_s, inc_s, rsp_s, dec_s;
  logic counting_s, timeout_err_s;

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  // Select the cycle/strobe of the current owner and the cycle of the other master.
  always_comb begin
    owner_cyc_s = 1'b0;
    owner_stb_s = 1'b0;
    other_cyc_s = 1'b0;
    case (state_r)
      BUS0: begin
        owner_cyc_s = m0_wb_cyc_i;
        owner_stb_s = m0_wb_stb_i;
        other_cyc_s = m1_wb_cyc_i;
      end
      BUS1: begin
        owner_cyc_s = m1_wb_cyc_i;
        owner_stb_s = m1_wb_stb_i;
        other_cyc_s = m0_wb_cyc_i;
      end
      default: begin
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        other_cyc_s = 1'b0;
      end
    endcase
  end

  assign full_s     = (outstanding_r == MAX_CNT);
  assign pending_s  = (outstanding_r != CNT_ZERO);
  assign req_s      = owner_cyc_s & owner_stb_s & ~full_s;
  assign inc_s      = req_s & ~s_wb_stall_i;
  // Responses with nothing outstanding are stale (e.g. after an abort) and dropped.
  assign rsp_s      = pending_s & (s_wb_ack_i | s_wb_err_i);
  assign counting_s = owner_cyc_s & pending_s & ~(s_wb_ack_i | s_wb_err_i);
  assign timeout_err_s = counting_s & ((timer_r + 8'd1) == TIMEOUT_CNT);
  assign dec_s      = rsp_s | timeout_err_s;

  // Slave-side mux and per-master stall/ack/err steering.
  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_adr_o    = {ADDR_WIDTH{1'b0}};
    s_wb_dat_o    = {DATA_WIDTH{1'b0}};
    s_wb_sel_o    = {SEL_WIDTH{1'b0}};
    m0_wb_stall_o = m0_wb_stb_i;
    m1_wb_stall_o = m1_wb_stb_i;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    case (state_r)
      BUS0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = req_s;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        m0_wb_stall_o = s_wb_stall_i | full_s;
        m0_wb_ack_o   = s_wb_ack_i & pending_s;
        m0_wb_err_o   = (s_wb_err_i & pending_s) | timeout_err_s;
      end
      BUS1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = req_s;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        m1_wb_stall_o = s_wb_stall_i | full_s;
        m1_wb_ack_o   = s_wb_ack_i & pending_s;
        m1_wb_err_o   = (s_wb_err_i & pending_s) | timeout_err_s;
      end
      default: begin
        s_wb_cyc_o = 1'b0;
      end
    endcase
  end

  // Next-state, grant history, outstanding counter and timeout timer.
  always_comb begin
    state_nxt_s       = state_r;
    last_grant_nxt_s  = last_grant_r;
    outstanding_nxt_s = outstanding_r;
    timer_nxt_s       = timer_r;
    case (state_r)
      IDLE: begin
        outstanding_nxt_s = CNT_ZERO;
        timer_nxt_s       = 8'd0;
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          if (last_grant_r) begin
            state_nxt_s      = BUS0;
            last_grant_nxt_s = 1'b0;
          end else begin
            state_nxt_s      = BUS1;
            last_grant_nxt_s = 1'b1;
          end
        end else if (m0_wb_cyc_i) begin
          state_nxt_s      = BUS0;
          last_grant_nxt_s = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_nxt_s      = BUS1;
          last_grant_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS0, BUS1: begin
        if (!owner_cyc_s) begin
          outstanding_nxt_s = CNT_ZERO;
          timer_nxt_s       = 8'd0;
          if (pending_s) begin
            state_nxt_s = IDLE;
          end else if (other_cyc_s) begin
            // Hand straight over to the waiting master without a dead cycle.
            state_nxt_s      = (state_r == BUS1) ? BUS0 : BUS1;
            last_grant_nxt_s = (state_r != BUS1);
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          if (inc_s && !dec_s) begin
            outstanding_nxt_s = outstanding_r + CNT_ONE;
          end else if (dec_s && !inc_s) begin
            outstanding_nxt_s = outstanding_r - CNT_ONE;
          end else begin
            outstanding_nxt_s = outstanding_r;
          end
          if (counting_s && !timeout_err_s) begin
            timer_nxt_s = timer_r + 8'd1;
          end else begin
            timer_nxt_s = 8'd0;
          end
        end
      end
      default: begin
        state_nxt_s       = IDLE;
        last_grant_nxt_s  = 1'b1;
        outstanding_nxt_s = CNT_ZERO;
        timer_nxt_s       = 8'd0;
      end
    endcase
  end

  // State registers; reset makes m0 win the first tie.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r       <= IDLE;
      last_grant_r  <= 1'b1;
      outstanding_r <= CNT_ZERO;
      timer_r       <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      last_grant_r  <= last_grant_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      timer_r       <= timer_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Directed bench for wb_arbiter_2m1s: a cycle vector table plus hand-written
// sequences for pipelining, timeout, abort and mid-transaction reset.
module tb_wb_arbiter_2m1s;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_adr = 32'h0, m0_dat = 32'h0;
  logic [3:0]  m0_sel = 4'hF;
  logic        m0_stall, m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_adr = 32'h0, m1_dat = 32'h0;
  logic [3:0]  m1_sel = 4'hF;
  logic        m1_stall, m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        s_stall = 1'b0, s_err = 1'b0;
  logic        s_ack;
  logic [31:0] s_rdat;

  wb_arbiter_2m1s #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_adr_i(m0_adr),
    .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel), .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack),
    .m0_wb_err_o(m0_err), .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_adr_i(m1_adr),
    .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel), .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack),
    .m1_wb_err_o(m1_err), .m1_wb_dat_o(m1_rdat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel), .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack),
    .s_wb_err_i(s_err), .s_wb_dat_i(s_rdat)
  );

  // Slave model: read data = adr ^ A5A50000, acked ack_delay cycles after acceptance.
  int unsigned ack_delay = 1;
  bit          slave_on = 1'b1;
  bit          q_v [8];
  bit [31:0]   q_d [8];
  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      q_v[i] <= q_v[i+1];
      q_d[i] <= q_d[i+1];
    end
    q_v[7] <= 1'b0;
    q_d[7] <= 32'h0;
    if (s_stb && !s_stall) begin
      q_v[ack_delay-1] <= 1'b1;
      q_d[ack_delay-1] <= s_adr ^ 32'hA5A5_0000;
    end
  end
  assign s_ack  = q_v[0] & slave_on;
  assign s_rdat = q_v[0] ? q_d[0] : 32'h0;

  logic [7:0] flags;
  assign flags = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic c0, input logic s0, input logic [31:0] a0,
                       input logic c1, input logic s1, input logic [31:0] a1);
    m0_cyc = c0; m0_stb = s0; m0_adr = a0;
    m1_cyc = c1; m1_stb = s1; m1_adr = a1;
  endtask

  // flags = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err}
  typedef struct {
    bit          rst;
    bit          c0, s0;
    logic [31:0] a0;
    bit          c1, s1;
    logic [31:0] a1;
    logic [7:0]  fl;
    logic [31:0] adr;
    logic [31:0] dat;
  } vec_t;

  vec_t tbl [23];

  // Pipelined m1 reads with 3-cycle ack latency
  bit          p_stb [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic [31:0] p_adr [9] = '{32'h100, 32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h0, 32'h0, 32'h0};
  bit          p_stl [9] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
  bit          p_sst [9] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
  bit          p_ack [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
  logic [31:0] p_dat [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0100, 32'hA5A5_0104, 32'h0, 32'h0, 32'hA5A5_0108};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h00, 0, 0, 32'h00, 8'b0000_0000, 32'h00, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h10, 0, 0, 32'h00, 8'b0010_0000, 32'h00, 32'h0};
    tbl[2]  = '{0, 1, 1, 32'h10, 0, 0, 32'h00, 8'b1100_0000, 32'h10, 32'h0};
    tbl[3]  = '{0, 1, 0, 32'h10, 0, 0, 32'h00, 8'b1000_1000, 32'h10, 32'hA5A5_0010};
    tbl[4]  = '{0, 0, 0, 32'h10, 0, 0, 32'h00, 8'b0000_0000, 32'h10, 32'h0};
    tbl[5]  = '{0, 0, 0, 32'h00, 0, 0, 32'h00, 8'b0000_0000, 32'h00, 32'h0};
    tbl[6]  = '{1, 1, 1, 32'h20, 1, 1, 32'h40, 8'b0011_0000, 32'h00, 32'h0};
    tbl[7]  = '{0, 1, 1, 32'h20, 1, 1, 32'h40, 8'b1101_0000, 32'h20, 32'h0};
    tbl[8]  = '{0, 1, 1, 32'h24, 1, 1, 32'h40, 8'b1101_1000, 32'h24, 32'hA5A5_0020};
    tbl[9]  = '{0, 1, 1, 32'h28, 1, 1, 32'h40, 8'b1101_1000, 32'h28, 32'hA5A5_0024};
    tbl[10] = '{0, 1, 0, 32'h28, 1, 1, 32'h40, 8'b1001_1000, 32'h28, 32'hA5A5_0028};
    tbl[11] = '{0, 0, 0, 32'h28, 1, 1, 32'h40, 8'b0001_0000, 32'h28, 32'h0};
    tbl[12] = '{0, 0, 0, 32'h00, 1, 1, 32'h40, 8'b1100_0000, 32'h40, 32'h0};
    tbl[13] = '{0, 0, 0, 32'h00, 1, 0, 32'h40, 8'b1000_0100, 32'h40, 32'hA5A5_0040};
    tbl[14] = '{0, 0, 0, 32'h00, 0, 0, 32'h40, 8'b0000_0000, 32'h40, 32'h0};
    tbl[15] = '{0, 1, 1, 32'h30, 1, 1, 32'h44, 8'b0011_0000, 32'h00, 32'h0};
    tbl[16] = '{0, 1, 1, 32'h30, 1, 1, 32'h44, 8'b1101_0000, 32'h30, 32'h0};
    tbl[17] = '{0, 1, 0, 32'h30, 1, 1, 32'h44, 8'b1001_1000, 32'h30, 32'hA5A5_0030};
    tbl[18] = '{0, 0, 0, 32'h30, 1, 1, 32'h44, 8'b0001_0000, 32'h30, 32'h0};
    tbl[19] = '{0, 0, 0, 32'h00, 1, 1, 32'h44, 8'b1100_0000, 32'h44, 32'h0};
    tbl[20] = '{0, 0, 0, 32'h00, 1, 0, 32'h44, 8'b1000_0100, 32'h44, 32'hA5A5_0044};
    tbl[21] = '{0, 0, 0, 32'h00, 0, 0, 32'h44, 8'b0000_0000, 32'h44, 32'h0};
    tbl[22] = '{0, 0, 0, 32'h00, 0, 0, 32'h00, 8'b0000_0000, 32'h00, 32'h0};

    #23;
    rst_n = 1'b1;

    ack_delay = 1;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (tbl[i].rst) pulse_rst();
      drive(tbl[i].c0, tbl[i].s0, tbl[i].a0, tbl[i].c1, tbl[i].s1, tbl[i].a1);
      #4;
      chk($sformatf("vec%0d_flags", i), {24'h0, flags}, {24'h0, tbl[i].fl});
      chk($sformatf("vec%0d_adr", i), s_adr, tbl[i].adr);
      if (tbl[i].fl[3] || tbl[i].fl[2]) begin
        chk($sformatf("vec%0d_dat0", i), m0_rdat, tbl[i].dat);
        chk($sformatf("vec%0d_dat1", i), m1_rdat, tbl[i].dat);
      end
    end

    ack_delay = 3;
    for (int p = 0; p < 9; p++) begin
      tick();
      if (p == 0) pulse_rst();
      drive(1'b0, 1'b0, 32'h0, 1'b1, p_stb[p], p_adr[p]);
      #4;
      chk($sformatf("pipe%0d_stall", p), {31'h0, m1_stall}, {31'h0, p_stl[p]});
      chk($sformatf("pipe%0d_sstb", p), {31'h0, s_stb}, {31'h0, p_sst[p]});
      chk($sformatf("pipe%0d_ack", p), {31'h0, m1_ack}, {31'h0, p_ack[p]});
      if (p_ack[p]) chk($sformatf("pipe%0d_dat", p), m1_rdat, p_dat[p]);
      if (p_sst[p]) chk($sformatf("pipe%0d_adr", p), s_adr, p_adr[p]);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    // Abort with one outstanding; the late ack must be dropped in IDLE.
    tick(); pulse_rst(); drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
    #4; chk("abort_b1_sstb", {31'h0, s_stb}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #4; chk("abort_b2_ack0", {31'h0, m0_ack}, 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h60);
    #4;
    chk("abort_b4_ack0", {31'h0, m0_ack}, 32'h0);
    chk("abort_b4_ack1", {31'h0, m1_ack}, 32'h0);
    chk("abort_b4_scyc", {31'h0, s_cyc}, 32'h0);
    chk("abort_b4_stall1", {31'h0, m1_stall}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h60);
    #4;
    chk("abort_b5_sstb", {31'h0, s_stb}, 32'h1);
    chk("abort_b5_adr", s_adr, 32'h60);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h64);
    #4; chk("abort_b6_stall", {31'h0, m1_stall}, 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h68);
    #4; chk("abort_b7_stall", {31'h0, m1_stall}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    // Silent slave: err must pulse on the 8th idle cycle after acceptance.
    slave_on = 1'b0;
    tick(); pulse_rst(); drive(1'b1, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
    #4; chk("tmo_t1_sstb", {31'h0, s_stb}, 32'h1);
    for (int t = 2; t <= 10; t++) begin
      tick(); drive(1'b1, 1'b0, 32'h90, 1'b0, 1'b0, 32'h0);
      #4;
      chk($sformatf("tmo_t%0d_err", t), {31'h0, m0_err}, {31'h0, (t == 9)});
      chk($sformatf("tmo_t%0d_ack", t), {31'h0, m0_ack}, 32'h0);
      chk($sformatf("tmo_t%0d_err1", t), {31'h0, m1_err}, 32'h0);
    end
    tick(); drive(1'b1, 1'b1, 32'h94, 1'b0, 1'b0, 32'h0);
    #4; chk("tmo_t11_stall", {31'h0, m0_stall}, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h98, 1'b0, 1'b0, 32'h0);
    #4; chk("tmo_t12_stall", {31'h0, m0_stall}, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h9C, 1'b0, 1'b0, 32'h0);
    #4; chk("tmo_t13_stall", {31'h0, m0_stall}, 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) tick();
    slave_on = 1'b1;

    // Reset in the middle of a BUS1 transfer, then a contention grants m0.
    tick(); pulse_rst(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h70);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h70);
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h74);
    #1;
    chk("rst_pre_scyc", {31'h0, s_cyc}, 32'h1);
    chk("rst_pre_sstb", {31'h0, s_stb}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_scyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_in_sstb", {31'h0, s_stb}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 32'h74);
    #1;
    chk("rst_idle_flags", {24'h0, flags}, {24'h0, 8'b0001_0000});
    tick(); drive(1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 32'h74);
    #4;
    chk("rst_c3_flags", {24'h0, flags}, {24'h0, 8'b1001_0000});
    chk("rst_c3_adr", s_adr, 32'h80);
    tick(); drive(1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 32'h74);
    #4; chk("rst_c4_stale_ack", {31'h0, m0_ack}, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h84, 1'b1, 1'b1, 32'h74);
    #4; chk("rst_c5_stall", {31'h0, m0_stall}, 32'h0);
    tick(); drive(1'b1, 1'b1, 32'h88, 1'b1, 1'b1, 32'h74);
    #4; chk("rst_c6_stall", {31'h0, m0_stall}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, 1'b0, 32'h88, 1'b0, 1'b0, 32'h0);
    end
    tick(); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
